id_stage_p: RTL and testbench

ID_STAGE_P -- requirements
Module: id_stage_p

---
 rtl/id_stage_p.sv | 139 +++++++++++++
 tb/tb_id_stage_p.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_p.sv
// Instruction-decode stage: latches the fetched instruction, decodes its fields and
// reads two register operands from an internal register file with write-through bypass.
`ifndef NOP
`define NOP 32'h0000_0000
`endif
`ifndef HALT
`define HALT 6'h3F
`endif

module id_stage_p #(
  parameter int WIDTH        = 32,
  parameter int REG_ADDR_LEN = 5,
  parameter bit IMM_SIGNED   = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [31:0]             IR_in,
  input  logic [WIDTH-3:0]        PC_in,
  input  logic                    in_valid,
  input  logic                    IsStall,
  input  logic                    IsFlush,
  input  logic                    wb_en,
  input  logic [REG_ADDR_LEN-1:0] wb_addr,
  input  logic [WIDTH-1:0]        wb_data,
  output logic [31:0]             IR,
  output logic [WIDTH-3:0]        PC,
  output logic                    out_valid,
  output logic [5:0]              OpCode,
  output logic [REG_ADDR_LEN-1:0] Rd_no,
  output logic [REG_ADDR_LEN-1:0] Rs_no,
  output logic [REG_ADDR_LEN-1:0] Rt_no,
  output logic [WIDTH-1:0]        Rs_val,
  output logic [WIDTH-1:0]        Rt_val,
  output logic [WIDTH-1:0]        Imm_ext,
  output logic [25:0]             Tgt,
  output logic                    halted
);

  localparam int          NREGS     = 2 ** REG_ADDR_LEN;
  localparam logic [31:0] NOP_INSTR = `NOP;
  localparam logic [5:0]  HALT_OP   = `HALT;

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [WIDTH-1:0]        regs_q [NREGS];
  logic [31:0]             ir_q, ir_d;
  logic [WIDTH-3:0]        pc_q, pc_d;
  logic                    vld_q, vld_d;
  logic [WIDTH-1:0]        rs_val_q, rs_val_d;
  logic [WIDTH-1:0]        rt_val_q, rt_val_d;

  logic [31:0]             cap_ir;
  logic [REG_ADDR_LEN-1:0] cap_rs, cap_rt;
  logic [WIDTH-1:0]        cap_rs_val, cap_rt_val;

  function automatic logic [WIDTH-1:0] ext_imm(input logic [15:0] imm);
    if (IMM_SIGNED) ext_imm = {{(WIDTH-16){imm[15]}}, imm};
    else            ext_imm = {{(WIDTH-16){1'b0}}, imm};
  endfunction

  // An invalid fetch slot is decoded as a NOP, so its operand reads hit r0.
  always_comb begin
    cap_ir     = in_valid ? IR_in : NOP_INSTR;
    cap_rs     = cap_ir[16 +: REG_ADDR_LEN];
    cap_rt     = cap_ir[11 +: REG_ADDR_LEN];
    cap_rs_val = regs_q[cap_rs];
    cap_rt_val = regs_q[cap_rt];
    if (wb_en && (wb_addr == cap_rs)) cap_rs_val = wb_data;
    if (wb_en && (wb_addr == cap_rt)) cap_rt_val = wb_data;
    if (cap_rs == '0) cap_rs_val = '0;
    if (cap_rt == '0) cap_rt_val = '0;
  end

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    pc_d     = pc_q;
    vld_d    = vld_q;
    rs_val_d = rs_val_q;
    rt_val_d = rt_val_q;
    if (state_q == HALTED || IsStall) begin
      // frozen: everything holds
    end else if (IsFlush) begin
      ir_d     = NOP_INSTR;
      vld_d    = 1'b0;
      rs_val_d = '0;
      rt_val_d = '0;
    end else begin
      ir_d     = cap_ir;
      pc_d     = PC_in;
      vld_d    = in_valid;
      rs_val_d = cap_rs_val;
      rt_val_d = cap_rt_val;
      if (in_valid && (IR_in[31:26] == HALT_OP)) state_d = HALTED;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      ir_q     <= NOP_INSTR;
      pc_q     <= '0;
      vld_q    <= 1'b0;
      rs_val_q <= '0;
      rt_val_q <= '0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      pc_q     <= pc_d;
      vld_q    <= vld_d;
      rs_val_q <= rs_val_d;
      rt_val_q <= rt_val_d;
    end
  end

  // Writes proceed regardless of stall or halt; r0 is never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wb_en && (wb_addr != '0)) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  assign IR        = ir_q;
  assign PC        = pc_q;
  assign out_valid = vld_q;
  assign OpCode    = ir_q[31:26];
  assign Rd_no     = ir_q[21 +: REG_ADDR_LEN];
  assign Rs_no     = ir_q[16 +: REG_ADDR_LEN];
  assign Rt_no     = ir_q[11 +: REG_ADDR_LEN];
  assign Tgt       = ir_q[25:0];
  assign Imm_ext   = ext_imm(ir_q[15:0]);
  assign Rs_val    = rs_val_q;
  assign Rt_val    = rt_val_q;
  assign halted    = (state_q == HALTED);

endmodule

// File: tb/tb_id_stage_p.sv
// Randomized scoreboard bench for id_stage_p: a driver updates a behavioural model and
// queues the expected post-edge state; a monitor pops and compares after every edge.
module tb_id_stage_p;

  localparam logic [31:0] NOP     = 32'h0000_0000;
  localparam logic [5:0]  HALT_OP = 6'h3F;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] IR_in = '0;
  logic [29:0] PC_in = '0;
  logic        in_valid = 1'b0, IsStall = 1'b0, IsFlush = 1'b0, wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;

  logic [31:0] IR, IRz;
  logic [29:0] PC, PCz;
  logic        out_valid, out_validz, halted, haltedz;
  logic [5:0]  OpCode, OpCodez;
  logic [4:0]  Rd_no, Rs_no, Rt_no, Rd_noz, Rs_noz, Rt_noz;
  logic [31:0] Rs_val, Rt_val, Imm_ext, Rs_valz, Rt_valz, Imm_extz;
  logic [25:0] Tgt, Tgtz;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_stage_p #(.WIDTH(32), .REG_ADDR_LEN(5), .IMM_SIGNED(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .IR_in(IR_in), .PC_in(PC_in), .in_valid(in_valid),
    .IsStall(IsStall), .IsFlush(IsFlush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .IR(IR), .PC(PC), .out_valid(out_valid), .OpCode(OpCode), .Rd_no(Rd_no), .Rs_no(Rs_no),
    .Rt_no(Rt_no), .Rs_val(Rs_val), .Rt_val(Rt_val), .Imm_ext(Imm_ext), .Tgt(Tgt), .halted(halted)
  );

  id_stage_p #(.WIDTH(32), .REG_ADDR_LEN(5), .IMM_SIGNED(1'b0)) u_dutz (
    .clk(clk), .rst_n(rst_n), .IR_in(IR_in), .PC_in(PC_in), .in_valid(in_valid),
    .IsStall(IsStall), .IsFlush(IsFlush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .IR(IRz), .PC(PCz), .out_valid(out_validz), .OpCode(OpCodez), .Rd_no(Rd_noz), .Rs_no(Rs_noz),
    .Rt_no(Rt_noz), .Rs_val(Rs_valz), .Rt_val(Rt_valz), .Imm_ext(Imm_extz), .Tgt(Tgtz),
    .halted(haltedz)
  );

  typedef struct {
    logic [31:0] ir;
    logic [29:0] pc;
    logic        vld;
    logic        hlt;
    logic [31:0] rsv;
    logic [31:0] rtv;
  } exp_t;

  exp_t q[$];

  // Architectural model: register contents and what the stage currently shows.
  logic [31:0] m_regs [32];
  logic [31:0] m_ir;
  logic [29:0] m_pc;
  logic        m_vld, m_hlt;
  logic [31:0] m_rsv, m_rtv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_ir = NOP; m_pc = '0; m_vld = 1'b0; m_hlt = 1'b0; m_rsv = '0; m_rtv = '0;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a, input logic we,
                                             input logic [4:0] wa, input logic [31:0] wd);
    if (a == 0) return 32'h0;
    if (we && wa == a) return wd;
    return m_regs[a];
  endfunction

  task automatic step(input logic [31:0] ir, input logic [29:0] pc, input logic v,
                      input logic st, input logic fl, input logic we,
                      input logic [4:0] wa, input logic [31:0] wd);
    exp_t e;
    logic [31:0] eff;
    @(posedge clk); #2;
    rst_n = 1'b1;
    IR_in = ir; PC_in = pc; in_valid = v; IsStall = st; IsFlush = fl;
    wb_en = we; wb_addr = wa; wb_data = wd;
    if (m_hlt || st) begin
      // outputs frozen
    end else if (fl) begin
      m_ir = NOP; m_vld = 1'b0; m_rsv = '0; m_rtv = '0;
    end else begin
      eff   = v ? ir : NOP;
      m_ir  = eff;
      m_pc  = pc;
      m_vld = v;
      m_rsv = model_read(eff[20:16], we, wa, wd);
      m_rtv = model_read(eff[15:11], we, wa, wd);
      if (v && ir[31:26] == HALT_OP) m_hlt = 1'b1;
    end
    if (we && wa != 0) m_regs[wa] = wd;
    e.ir = m_ir; e.pc = m_pc; e.vld = m_vld; e.hlt = m_hlt; e.rsv = m_rsv; e.rtv = m_rtv;
    q.push_back(e);
  endtask

  // Reset asserted asynchronously between edges; outputs must clear at once.
  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst_IR", IR, NOP);
    chk("rst_PC", {2'b0, PC}, 32'h0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'h0);
    chk("rst_Rs_val", Rs_val, 32'h0);
    chk("rst_Rt_val", Rt_val, 32'h0);
    chk("rst_Imm_ext", Imm_ext, 32'h0);
    chk("rst_Tgt", {6'b0, Tgt}, 32'h0);
    IsStall = 1'b0; IsFlush = 1'b0; in_valid = 1'b0; wb_en = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] f1,
                                     input logic [4:0] f2, input logic [15:0] lo);
    return {op, f1, f2, lo};
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("IR", IR, e.ir);
        chk("PC", {2'b0, PC}, {2'b0, e.pc});
        chk("out_valid", {31'b0, out_valid}, {31'b0, e.vld});
        chk("halted", {31'b0, halted}, {31'b0, e.hlt});
        chk("OpCode", {26'b0, OpCode}, {26'b0, e.ir[31:26]});
        chk("Rd_no", {27'b0, Rd_no}, {27'b0, e.ir[25:21]});
        chk("Rs_no", {27'b0, Rs_no}, {27'b0, e.ir[20:16]});
        chk("Rt_no", {27'b0, Rt_no}, {27'b0, e.ir[15:11]});
        chk("Tgt", {6'b0, Tgt}, {6'b0, e.ir[25:0]});
        chk("Rs_val", Rs_val, e.rsv);
        chk("Rt_val", Rt_val, e.rtv);
        chk("Imm_ext_signed", Imm_ext, {{16{e.ir[15]}}, e.ir[15:0]});
        chk("Imm_ext_zero", Imm_extz, {16'h0, e.ir[15:0]});
        chk("halted_z", {31'b0, haltedz}, {31'b0, e.hlt});
      end
    end
  end

  initial begin : driver
    logic [31:0] r_ir, r_wd;
    logic [4:0]  r_wa;
    model_reset();
    rst_n = 1'b0;
    #1;
    chk("por_IR", IR, NOP);
    chk("por_out_valid", {31'b0, out_valid}, 32'h0);
    repeat (2) @(posedge clk);

    // Write r3 then read it as Rs.
    step(NOP, 30'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h0000_00AA);
    step(mk(6'h01, 5'd0, 5'd3, 16'h0000), 30'd1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    // Same-cycle bypass to Rt, and write to r0 being ignored.
    step(mk(6'h02, 5'd1, 5'd0, {5'd5, 11'h0}), 30'd2, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 32'h1234_5678);
    step(mk(6'h02, 5'd1, 5'd0, {5'd0, 11'h0}), 30'd3, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'h1234_5678);
    // Immediate extension.
    step(mk(6'h08, 5'd2, 5'd5, 16'h8001), 30'd4, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    // Stall three cycles with changing input and writes, then stall+flush, then flush.
    for (int i = 0; i < 3; i++)
      step($urandom & 32'h03FF_FFFF, 30'(100 + i), 1'b1, 1'b1, 1'b0, 1'b1, 5'(7 + i), $urandom);
    step(mk(6'h04, 5'd7, 5'd8, 16'h1234), 30'd200, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
    step(mk(6'h04, 5'd7, 5'd8, 16'h1234), 30'd201, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
    step(mk(6'h04, 5'd7, 5'd8, {5'd9, 11'h0}), 30'd202, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);

    // Randomized traffic (no HALT opcodes).
    for (int i = 0; i < 300; i++) begin
      r_ir = $urandom;
      if (r_ir[31:26] == HALT_OP) r_ir[31:26] = 6'h00;
      r_wa = ($urandom_range(0, 2) == 0) ? r_ir[20:16] : 5'($urandom);
      r_wd = $urandom;
      step(r_ir, 30'($urandom), ($urandom_range(0, 5) != 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 4) == 0), 1'($urandom), r_wa, r_wd);
    end

    // Reset in the middle of a stall.
    step(mk(6'h01, 5'd1, 5'd2, 16'h0), 30'd5, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    do_reset();
    step(mk(6'h01, 5'd1, 5'd3, {5'd4, 11'h0}), 30'd6, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 32'hCAFE_0003);

    // HALT: later instructions, flushes and stalls are ignored, writes still land.
    step(mk(HALT_OP, 5'd1, 5'd3, 16'h00FF), 30'd7, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 6; i++)
      step(mk(6'h05, 5'd2, 5'd3, 16'h4444), 30'(300 + i), 1'b1, (i == 4), (i[0] == 1'b1),
           1'b1, 5'(10 + i), $urandom);
    do_reset();
    // Registers must read 0 after reset.
    step(mk(6'h01, 5'd0, 5'd3, {5'd10, 11'h0}), 30'd9, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step(mk(6'h01, 5'd0, 5'd11, {5'd12, 11'h0}), 30'd10, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);

    @(posedge clk); #3;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
